// File: rtl/issue_unit_if.sv
// Decode-side, scoreboard-side and issue-side signal bundle of the in-order issue stage.
// The slave modport is the issue unit; the master modport is its environment.
`timescale 1ns/1ps
interface issue_unit_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic        dec_rs_used;
  logic        dec_rt_used;
  logic [4:0]  dec_rd;
  logic        dec_writes;
  logic [1:0]  dec_fu;
  logic [31:0] pnd_sgn;
  logic [3:0]  fu_busy;
  logic [4:0]  sb_reg_addr;
  logic [1:0]  sb_func_uni;
  logic        sb_wre;
  logic        iss_valid;
  logic [4:0]  iss_rs;
  logic [4:0]  iss_rt;
  logic [4:0]  iss_rd;
  logic [1:0]  iss_fu;
  logic [15:0] stall_cnt;

  modport master (
    output dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used, dec_rd, dec_writes, dec_fu,
    output pnd_sgn, fu_busy,
    input  dec_ready, sb_reg_addr, sb_func_uni, sb_wre,
    input  iss_valid, iss_rs, iss_rt, iss_rd, iss_fu, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used, dec_rd, dec_writes, dec_fu,
    input  pnd_sgn, fu_busy,
    output dec_ready, sb_reg_addr, sb_func_uni, sb_wre,
    output iss_valid, iss_rs, iss_rt, iss_rd, iss_fu, stall_cnt
  );
endinterface

// File: rtl/issue_unit.sv
// Single-slot in-order issue stage with RAW/WAW/structural hazard checks against the scoreboard.
// Optional hazard-stall counter enabled by defining ISSUE_STALL_CNT_EN.
`timescale 1ns/1ps
module issue_unit (
  input  logic         clock,
  input  logic         reset,
  issue_unit_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t      state;
  logic [4:0]  h_rs;
  logic [4:0]  h_rt;
  logic [4:0]  h_rd;
  logic        h_rs_used;
  logic        h_rt_used;
  logic        h_writes;
  logic [1:0]  h_fu;

  logic        iss_valid_q;
  logic [4:0]  iss_rs_q;
  logic [4:0]  iss_rt_q;
  logic [4:0]  iss_rd_q;
  logic [1:0]  iss_fu_q;
  logic        sb_wre_q;
  logic [4:0]  sb_reg_addr_q;
  logic [1:0]  sb_func_uni_q;

  logic        hz;
  logic        fire;
  logic        ready;
  logic        take;

  // A mark still in flight to the scoreboard counts as pending until pnd_sgn shows it.
  function automatic logic pend(input logic [4:0] r, input logic [31:0] vec,
                                input logic wre_n, input logic [4:0] addr);
    return (r != 5'd0) && (vec[r] || (!wre_n && (addr == r)));
  endfunction

  assign hz = (h_rs_used && pend(h_rs, bus.pnd_sgn, sb_wre_q, sb_reg_addr_q))
            | (h_rt_used && pend(h_rt, bus.pnd_sgn, sb_wre_q, sb_reg_addr_q))
            | (h_writes  && pend(h_rd, bus.pnd_sgn, sb_wre_q, sb_reg_addr_q))
            | bus.fu_busy[h_fu];

  assign fire  = (state == HELD) && !hz;
  assign ready = (state == EMPTY) || fire;
  assign take  = bus.dec_valid && ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= EMPTY;
      h_rs          <= 5'd0;
      h_rt          <= 5'd0;
      h_rd          <= 5'd0;
      h_rs_used     <= 1'b0;
      h_rt_used     <= 1'b0;
      h_writes      <= 1'b0;
      h_fu          <= 2'd0;
      iss_valid_q   <= 1'b0;
      iss_rs_q      <= 5'd0;
      iss_rt_q      <= 5'd0;
      iss_rd_q      <= 5'd0;
      iss_fu_q      <= 2'd0;
      sb_wre_q      <= 1'b1;
      sb_reg_addr_q <= 5'd0;
      sb_func_uni_q <= 2'd0;
    end else begin
      if (take) begin
        state     <= HELD;
        h_rs      <= bus.dec_rs;
        h_rt      <= bus.dec_rt;
        h_rd      <= bus.dec_rd;
        h_rs_used <= bus.dec_rs_used;
        h_rt_used <= bus.dec_rt_used;
        h_writes  <= bus.dec_writes;
        h_fu      <= bus.dec_fu;
      end else if (fire) begin
        state <= EMPTY;
      end

      iss_valid_q <= fire;
      sb_wre_q    <= 1'b1;
      if (fire) begin
        iss_rs_q <= h_rs;
        iss_rt_q <= h_rt;
        iss_rd_q <= h_rd;
        iss_fu_q <= h_fu;
        // Register 0 is hardwired, so it is never marked pending.
        if (h_writes && (h_rd != 5'd0)) begin
          sb_wre_q      <= 1'b0;
          sb_reg_addr_q <= h_rd;
          sb_func_uni_q <= h_fu;
        end
      end
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'h0000;
    end else if ((state == HELD) && hz && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

  assign bus.dec_ready   = ready;
  assign bus.iss_valid   = iss_valid_q;
  assign bus.iss_rs      = iss_rs_q;
  assign bus.iss_rt      = iss_rt_q;
  assign bus.iss_rd      = iss_rd_q;
  assign bus.iss_fu      = iss_fu_q;
  assign bus.sb_wre      = sb_wre_q;
  assign bus.sb_reg_addr = sb_reg_addr_q;
  assign bus.sb_func_uni = sb_func_uni_q;

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard-driven bench for issue_unit: expected issues are queued on drive and popped on iss_valid.
// Stall-count expectations follow ISSUE_STALL_CNT_EN.
`timescale 1ns/1ps
module tb_issue_unit;

`ifdef ISSUE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  issue_unit_if bus();

  issue_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [1:0] fu;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  logic [31:0] pnd_force = 32'd0;
  logic [31:0] sb_model  = 32'd0;
  logic [31:0] sb_clear  = 32'd0;
  logic        model_en  = 1'b0;

  // Scoreboard model: latches a mark at the edge where sb_wre is low.
  always @(posedge clock)
    sb_model <= (sb_model & ~sb_clear) | ((model_en && !bus.sb_wre) ? (32'd1 << bus.sb_reg_addr) : 32'd0);

  assign bus.pnd_sgn = pnd_force | sb_model;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic rsu, input logic rtu, input logic wr, input logic [1:0] fu);
    exp_t e;
    bus.dec_valid   = 1'b1;
    bus.dec_rs      = rs;
    bus.dec_rt      = rt;
    bus.dec_rd      = rd;
    bus.dec_rs_used = rsu;
    bus.dec_rt_used = rtu;
    bus.dec_writes  = wr;
    bus.dec_fu      = fu;
    e.rs = rs; e.rt = rt; e.rd = rd; e.fu = fu;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.dec_valid = 1'b0;
    bus.fu_busy   = 4'b0000;
    pnd_force     = 32'd0;
    model_en      = 1'b0;
    sb_clear      = 32'hFFFF_FFFF;
    step();
    step();
    sb_clear = 32'd0;
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    step();
    check_cnt++; if (bus.dec_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", bus.dec_ready); else pass_cnt++;
    check_cnt++; if (bus.iss_valid !== 1'b0) $display("[TB] FAIL reset_iss_valid got=%b exp=0", bus.iss_valid); else pass_cnt++;
    check_cnt++; if (bus.sb_wre !== 1'b1) $display("[TB] FAIL reset_sb_wre got=%b exp=1", bus.sb_wre); else pass_cnt++;
    check_cnt++;
    if ({bus.sb_reg_addr, bus.sb_func_uni, bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu} !== 24'd0)
      $display("[TB] FAIL reset_fields got=%h exp=0", {bus.sb_reg_addr, bus.sb_func_uni, bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu});
    else pass_cnt++;
    check_cnt++; if (bus.stall_cnt !== 16'h0000) $display("[TB] FAIL reset_stall got=%h exp=0", bus.stall_cnt); else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    do_reset();
    drive_instr(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 2'd1);
    #1;
    check_cnt++; if (bus.dec_ready !== 1'b1) $display("[TB] FAIL basic_ready got=%b exp=1", bus.dec_ready); else pass_cnt++;
    step();
    bus.dec_valid = 1'b0;
    check_cnt++; if (bus.iss_valid !== 1'b0) $display("[TB] FAIL basic_early got=%b exp=0", bus.iss_valid); else pass_cnt++;
    step();
    check_cnt++; if (bus.iss_valid !== 1'b1) $display("[TB] FAIL basic_iss_valid got=%b exp=1", bus.iss_valid); else pass_cnt++;
    check_cnt++;
    if (exp_q.size() == 0) $display("[TB] FAIL basic_fields got=issue exp=none");
    else begin
      e = exp_q.pop_front();
      if ({bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu} !== {e.rs, e.rt, e.rd, e.fu})
        $display("[TB] FAIL basic_fields got=%h exp=%h", {bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu}, {e.rs, e.rt, e.rd, e.fu});
      else pass_cnt++;
    end
    check_cnt++;
    if ({bus.sb_wre, bus.sb_reg_addr, bus.sb_func_uni} !== {1'b0, 5'd5, 2'd1})
      $display("[TB] FAIL basic_mark got=%b_%0d_%0d exp=0_5_1", bus.sb_wre, bus.sb_reg_addr, bus.sb_func_uni);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({bus.iss_valid, bus.sb_wre, bus.sb_reg_addr} !== {1'b0, 1'b1, 5'd5})
      $display("[TB] FAIL basic_after got=%b_%b_%0d exp=0_1_5", bus.iss_valid, bus.sb_wre, bus.sb_reg_addr);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    model_en = 1'b1;
    drive_instr(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1, 2'd0);
    step();
    drive_instr(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 2'd3);
    #1;
    check_cnt++; if (bus.dec_ready !== 1'b1) $display("[TB] FAIL b2b_ready got=%b exp=1", bus.dec_ready); else pass_cnt++;
    step();
    bus.dec_valid = 1'b0;
    check_cnt++;
    if (exp_q.size() == 0 || bus.iss_valid !== 1'b1) $display("[TB] FAIL b2b_a_issue got=%b exp=1", bus.iss_valid);
    else begin
      e = exp_q.pop_front();
      if ({bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu, bus.sb_wre, bus.sb_reg_addr} !== {e.rs, e.rt, e.rd, e.fu, 1'b0, 5'd5})
        $display("[TB] FAIL b2b_a_fields got=%h exp=%h", {bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu, bus.sb_wre, bus.sb_reg_addr}, {e.rs, e.rt, e.rd, e.fu, 1'b0, 5'd5});
      else pass_cnt++;
    end
    #1;
    check_cnt++; if (bus.dec_ready !== 1'b0) $display("[TB] FAIL raw_bypass_hold got=%b exp=0", bus.dec_ready); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      check_cnt++; if (bus.iss_valid !== 1'b0) $display("[TB] FAIL raw_no_issue cyc=%0d got=%b exp=0", i, bus.iss_valid); else pass_cnt++;
      #1;
      check_cnt++; if (bus.dec_ready !== 1'b0) $display("[TB] FAIL raw_pend_hold cyc=%0d got=%b exp=0", i, bus.dec_ready); else pass_cnt++;
      if (i == 3) sb_clear = 32'h0000_0020;
    end
    step();
    sb_clear = 32'd0;
    #1;
    check_cnt++; if (bus.dec_ready !== 1'b1) $display("[TB] FAIL raw_release got=%b exp=1", bus.dec_ready); else pass_cnt++;
    step();
    check_cnt++;
    if (exp_q.size() == 0 || bus.iss_valid !== 1'b1) $display("[TB] FAIL b2b_b_issue got=%b exp=1", bus.iss_valid);
    else begin
      e = exp_q.pop_front();
      if ({bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu, bus.sb_wre, bus.sb_reg_addr, bus.sb_func_uni} !== {e.rs, e.rt, e.rd, e.fu, 1'b0, 5'd7, 2'd3})
        $display("[TB] FAIL b2b_b_fields got=%h exp=%h", {bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu, bus.sb_wre, bus.sb_reg_addr, bus.sb_func_uni}, {e.rs, e.rt, e.rd, e.fu, 1'b0, 5'd7, 2'd3});
      else pass_cnt++;
    end
    check_cnt++;
    if (bus.stall_cnt !== (CNT_EN ? 16'd5 : 16'd0)) $display("[TB] FAIL raw_stall_cnt got=%0d exp=%0d", bus.stall_cnt, CNT_EN ? 5 : 0);
    else pass_cnt++;
    model_en = 1'b0;
  endtask

  task automatic test_reg_zero();
    exp_t e;
    do_reset();
    pnd_force = 32'hFFFF_FFFF;
    drive_instr(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 2'd2);
    step();
    bus.dec_valid = 1'b0;
    #1;
    check_cnt++; if (bus.dec_ready !== 1'b1) $display("[TB] FAIL zero_fire got=%b exp=1", bus.dec_ready); else pass_cnt++;
    step();
    check_cnt++;
    if (exp_q.size() == 0 || bus.iss_valid !== 1'b1) $display("[TB] FAIL zero_issue got=%b exp=1", bus.iss_valid);
    else begin
      e = exp_q.pop_front();
      if ({bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu} !== {e.rs, e.rt, e.rd, e.fu})
        $display("[TB] FAIL zero_fields got=%h exp=%h", {bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu}, {e.rs, e.rt, e.rd, e.fu});
      else pass_cnt++;
    end
    check_cnt++; if (bus.sb_wre !== 1'b1) $display("[TB] FAIL zero_no_mark got=%b exp=1", bus.sb_wre); else pass_cnt++;
    check_cnt++; if (bus.stall_cnt !== 16'd0) $display("[TB] FAIL zero_stall got=%0d exp=0", bus.stall_cnt); else pass_cnt++;
    pnd_force = 32'd0;
  endtask

  task automatic test_fu_busy();
    exp_t e;
    do_reset();
    bus.fu_busy = 4'b0100;
    drive_instr(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.dec_valid = 1'b0;
      check_cnt++; if (bus.iss_valid !== 1'b0) $display("[TB] FAIL fu_no_issue cyc=%0d got=%b exp=0", i, bus.iss_valid); else pass_cnt++;
      #1;
      check_cnt++; if (bus.dec_ready !== 1'b0) $display("[TB] FAIL fu_busy_hold cyc=%0d got=%b exp=0", i, bus.dec_ready); else pass_cnt++;
    end
    step();
    bus.fu_busy = 4'b1011;
    #1;
    check_cnt++; if (bus.dec_ready !== 1'b1) $display("[TB] FAIL fu_release got=%b exp=1", bus.dec_ready); else pass_cnt++;
    step();
    check_cnt++;
    if (exp_q.size() == 0 || bus.iss_valid !== 1'b1) $display("[TB] FAIL fu_issue got=%b exp=1", bus.iss_valid);
    else begin
      e = exp_q.pop_front();
      if ({bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu, bus.sb_wre, bus.sb_reg_addr, bus.sb_func_uni} !== {e.rs, e.rt, e.rd, e.fu, 1'b0, 5'd10, 2'd2})
        $display("[TB] FAIL fu_fields got=%h exp=%h", {bus.iss_rs, bus.iss_rt, bus.iss_rd, bus.iss_fu, bus.sb_wre, bus.sb_reg_addr, bus.sb_func_uni}, {e.rs, e.rt, e.rd, e.fu, 1'b0, 5'd10, 2'd2});
      else pass_cnt++;
    end
    check_cnt++;
    if (bus.stall_cnt !== (CNT_EN ? 16'd3 : 16'd0)) $display("[TB] FAIL fu_stall_cnt got=%0d exp=%0d", bus.stall_cnt, CNT_EN ? 3 : 0);
    else pass_cnt++;
    bus.fu_busy = 4'b0000;
  endtask

  task automatic test_stall_sat();
    exp_t e;
    do_reset();
    pnd_force = 32'd1 << 12;
    drive_instr(5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 2'd0);
    step();
    bus.dec_valid = 1'b0;
    repeat (70000) step();
    check_cnt++;
    if (bus.stall_cnt !== (CNT_EN ? 16'hFFFF : 16'h0000)) $display("[TB] FAIL stall_saturate got=%h exp=%h", bus.stall_cnt, CNT_EN ? 16'hFFFF : 16'h0000);
    else pass_cnt++;
    check_cnt++; if (bus.iss_valid !== 1'b0) $display("[TB] FAIL stall_no_issue got=%b exp=0", bus.iss_valid); else pass_cnt++;
    pnd_force = 32'd0;
    step();
    check_cnt++;
    if (exp_q.size() == 0 || bus.iss_valid !== 1'b1) $display("[TB] FAIL stall_issue got=%b exp=1", bus.iss_valid);
    else begin
      e = exp_q.pop_front();
      if ({bus.iss_rs, bus.iss_rd} !== {e.rs, e.rd}) $display("[TB] FAIL stall_fields got=%h exp=%h", {bus.iss_rs, bus.iss_rd}, {e.rs, e.rd});
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_held();
    do_reset();
    drive_instr(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1, 2'd0);
    step();
    drive_instr(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 2'd3);
    step();
    bus.dec_valid = 1'b0;
    void'(exp_q.pop_front());
    #1;
    check_cnt++;
    if ({bus.dec_ready, bus.iss_valid, bus.sb_wre} !== 3'b010) $display("[TB] FAIL rst_pre got=%b exp=010", {bus.dec_ready, bus.iss_valid, bus.sb_wre});
    else pass_cnt++;
    #1 reset = 1'b0;
    #1;
    check_cnt++;
    if ({bus.dec_ready, bus.iss_valid, bus.sb_wre} !== 3'b101) $display("[TB] FAIL rst_immediate got=%b exp=101", {bus.dec_ready, bus.iss_valid, bus.sb_wre});
    else pass_cnt++;
    exp_q.delete();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_cnt++; if (bus.iss_valid !== 1'b0) $display("[TB] FAIL rst_discard cyc=%0d got=%b exp=0", i, bus.iss_valid); else pass_cnt++;
    end
  endtask

  initial begin
    bus.dec_valid   = 1'b0;
    bus.dec_rs      = 5'd0;
    bus.dec_rt      = 5'd0;
    bus.dec_rd      = 5'd0;
    bus.dec_rs_used = 1'b0;
    bus.dec_rt_used = 1'b0;
    bus.dec_writes  = 1'b0;
    bus.dec_fu      = 2'd0;
    bus.fu_busy     = 4'b0000;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reg_zero();
    test_fu_busy();
    test_stall_sat();
    test_reset_held();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
# issue_unit

In-order issue stage that sits directly upstream of the register scoreboard. It accepts one decoded instruction at a time into a single holding slot and checks its source and destination registers against the scoreboard's 32-bit pending vector. It also checks a functional-unit busy vector. When the instruction is hazard-free it issues it to execution and drives the scoreboard's mark-pending write port, which is active-low.

## Interface
- No parameters; register file fixed at 32 entries, 4 functional units.
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  issue unit accepts instruction this cycle
- dec_rs, dec_rt  in  5 each  source register numbers
- dec_rs_used, dec_rt_used  in  1 each  source actually read
- dec_rd  in  5  destination register
- dec_writes  in  1  instruction writes dec_rd
- dec_fu  in  2  target functional unit
- pnd_sgn  in  32  scoreboard pending vector, bit r = register r pending
- fu_busy  in  4  bit f = functional unit f cannot accept this cycle
- sb_reg_addr  out  5  scoreboard mark address
- sb_func_uni  out  2  scoreboard functional-unit tag
- sb_wre  out  1  scoreboard mark strobe, active-low
- iss_valid  out  1  one-cycle issue pulse
- iss_rs, iss_rt, iss_rd  out  5 each; iss_fu  out  2  issued instruction fields
- stall_cnt  out  16  hazard-stall cycle counter

## Operation
- Two states: EMPTY (slot free), HELD (slot holds instruction).
- pend(r) = (r != 0) & (pnd_sgn[r] | (!sb_wre & sb_reg_addr == r)). The second term is the in-flight bypass covering the cycle before the scoreboard reflects a mark.
- hz = (rs_used & pend(rs)) | (rt_used & pend(rt)) | (writes & pend(rd)) | fu_busy[fu]; evaluated on held fields only. Covers RAW, WAW and structural hazards.
- fire = HELD & !hz.
- dec_ready = EMPTY | fire (combinational). Back-to-back issue is allowed.
- Transfer on dec_valid & dec_ready: fields load into slot, next state HELD.
- fire without transfer: next state EMPTY.
- HELD & hz: slot unchanged; stall_cnt increments, saturating at 0xFFFF.
- On fire, registered into the next cycle:
  - iss_valid=1 and all iss_* fields;
  - if writes & rd!=0: sb_wre=0, sb_reg_addr=rd, sb_func_uni=fu; otherwise sb_wre=1.
- In any cycle without fire: iss_valid=0, sb_wre=1; sb_reg_addr/sb_func_uni and iss_* hold their last value.
- Register 0 is never treated as pending and is never marked.

## Timing
- Reset values: state EMPTY, dec_ready=1, iss_valid=0, sb_wre=1, sb_reg_addr=0, sb_func_uni=0, iss_*=0, stall_cnt=0.
- Reset asserted mid-operation discards the held instruction immediately (asynchronous); no issue pulse is produced.
- Latency: an instruction accepted in cycle N fires in N+1 at the earliest; iss_valid and sb_wre are low/high as above in N+2.
- Scoreboard update timing: the scoreboard samples sb_wre low at the end of N+2, and pnd_sgn reflects the mark from N+3. The bypass term covers the dependent check made in N+2.
- fu_busy and pnd_sgn are sampled combinationally in the fire cycle only.

## Configuration
- ISSUE_STALL_CNT_EN defined: stall_cnt counter is implemented as described.
- Not defined: no counter flops; stall_cnt tied to 16'h0000.

## Test plan
- Reset, then dec_valid with rs=3, rt=4, rd=5, fu=1, pnd_sgn=0 -> iss_valid pulses 2 cycles after acceptance; sb_wre=0 with sb_reg_addr=5, sb_func_uni=1 in that same cycle only.
- Back-to-back RAW: instr A writes r5, instr B reads r5, pnd_sgn driven by a scoreboard model -> B held by the bypass term in the cycle after A fires, then by pnd_sgn[5]; B issues the cycle after bit 5 clears; stall_cnt equals the number of held cycles.
- pnd_sgn=32'hFFFFFFFF, instruction with rs=0, rt=0, rd=0, writes=1 -> issues with no stall and sb_wre stays 1.
- fu_busy=4'b0100, instruction fu=2 -> dec_ready=0 while busy; issue one cycle after fu_busy[2] drops.
- Hold a hazard for 70000 cycles -> stall_cnt saturates at 16'hFFFF (macro defined) or reads 0 (macro undefined).
- Assert reset while HELD with a hazard -> dec_ready=1, iss_valid=0 and sb_wre=1 immediately; the held instruction never issues.
